// File: rtl/mc_controller.sv
// Multicycle control unit: main sequencing FSM, ALU decoder and condition/flag logic
// for a shared-memory, shared-ALU ARM datapath.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_condexr;

    logic       w_nextpc, w_branch, w_regw, w_memw, w_irw, w_aluop;
    logic       w_cmd_nowrite, w_nowrite, w_condex;
    logic [1:0] w_flagw;
    logic [1:0] w_alu_ctrl;
    logic [3:0] w_cmd;
    logic       w_n, w_z, w_c, w_v;

    assign w_cmd = Funct[4:1];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_flags   <= '0;
            r_condexr <= 1'b1;
        end else begin
            case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    r_condexr <= w_condex;
                    case (Op)
                        2'b01:   r_state <= MEMADR;
                        2'b00:   r_state <= Funct[5] ? EXECI : EXECR;
                        2'b10:   r_state <= BRANCH;
                        default: r_state <= FETCH;
                    endcase
                end
                MEMADR: r_state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  r_state <= MEMWB;
                EXECR, EXECI: begin
                    if (w_flagw[1] & r_condexr) r_flags[3:2] <= ALUFlags[3:2];
                    if (w_flagw[0] & r_condexr) r_flags[1:0] <= ALUFlags[1:0];
                    r_state <= ALUWB;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    always_comb begin
        w_nextpc  = 1'b0;
        w_branch  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_irw     = 1'b0;
        w_aluop   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (r_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irw     = 1'b1;
                w_nextpc  = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            EXECR: w_aluop = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                w_aluop = 1'b1;
            end
            ALUWB:  w_regw = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // NoWrite is derived from the held cmd bits rather than ALUOp, since ALUWB runs with ALUOp=0;
    // it is confined to ALUWB so LDR address-mode bits in MEMWB never suppress the load.
    always_comb begin
        w_alu_ctrl    = 2'b00;
        w_cmd_nowrite = 1'b1;
        case (w_cmd)
            4'b0100: begin w_alu_ctrl = 2'b00; w_cmd_nowrite = 1'b0; end
            4'b0010: begin w_alu_ctrl = 2'b01; w_cmd_nowrite = 1'b0; end
            4'b0000: begin w_alu_ctrl = 2'b10; w_cmd_nowrite = 1'b0; end
            4'b1100: begin w_alu_ctrl = 2'b11; w_cmd_nowrite = 1'b0; end
            4'b1010: w_alu_ctrl = 2'b01;
            4'b1000: w_alu_ctrl = 2'b10;
            default: w_alu_ctrl = 2'b00;
        endcase
    end

    assign ALUControl = w_aluop ? w_alu_ctrl : 2'b00;
    assign w_flagw[1] = w_aluop & Funct[0];
    assign w_flagw[0] = w_aluop & Funct[0] & ~ALUControl[1];
    assign w_nowrite  = (r_state == ALUWB) & w_cmd_nowrite;

    always_comb begin
        case (Cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    assign RegWrite = ~reset & w_regw & r_condexr & ~w_nowrite;
    assign MemWrite = ~reset & w_memw & r_condexr;
    assign IRWrite  = ~reset & w_irw;
    assign PCWrite  = ~reset & (w_nextpc | (w_branch & r_condexr) |
                                (w_regw & (Rd == 4'd15) & r_condexr & ~w_nowrite));
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level reference model (step lists, flag arithmetic)
// compared every cycle, directed test-plan cases followed by randomized instructions.
module tb_mc_controller;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5,
                   S_ER = 6, S_EI = 7, S_AW = 8, S_BR = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

    mc_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic        chk_en = 1'b0;
    int          cur_step = -1;
    logic [15:0] exp_vec;
    logic [3:0]  m_flags;
    logic        m_cx;
    logic        pin_en = 1'b0;
    int          pin_id = 0;
    logic [3:0]  pin_exp = '0;
    logic        obs_rw = 1'b0, obs_br = 1'b0;

    wire [15:0] dut_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

    function automatic logic condex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0: return z;            4'd1: return !z;
            4'd2: return cy;           4'd3: return !cy;
            4'd4: return n;            4'd5: return !n;
            4'd6: return v;            4'd7: return !v;
            4'd8: return cy && !z;     4'd9: return !cy || z;
            4'd10: return n == v;      4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_sel(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000, 4'b1000: return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
    endfunction

    // What the control outputs must be during one step of the current instruction.
    function automatic logic [15:0] model_out(input int st);
        logic pcw, mw, rw, irw, adr, sa, aop, nw;
        logic [1:0] sb, rs, ctl;
        irw = (st == S_F);
        adr = (st == S_MR) || (st == S_MWR);
        sa  = (st == S_F) || (st == S_D);
        sb  = (st == S_F || st == S_D) ? 2'b10 :
              (st == S_MA || st == S_EI || st == S_BR) ? 2'b01 : 2'b00;
        rs  = (st == S_F || st == S_D || st == S_BR) ? 2'b10 : (st == S_MWB) ? 2'b01 : 2'b00;
        aop = (st == S_ER) || (st == S_EI);
        ctl = aop ? alu_sel(Funct[4:1]) : 2'b00;
        nw  = (st == S_AW) && !writes_reg(Funct[4:1]);
        rw  = (st == S_MWB || st == S_AW) && m_cx && !nw;
        mw  = (st == S_MWR) && m_cx;
        pcw = (st == S_F) || (st == S_BR && m_cx) || (rw && Rd == 4'd15);
        return {pcw, mw, rw, irw, adr, sa, sb, rs, ctl, Op, Op == 2'b01, Op == 2'b10};
    endfunction

    function automatic logic [15:0] reset_out();
        return {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, Op, Op == 2'b01, Op == 2'b10};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t step=%0d actual=%b required=%b",
                         $time, cur_step, dut_vec, exp_vec);
            end
            if (cur_step == S_F) begin
                if (pin_en) begin
                    logic [3:0] act;
                    case (pin_id)
                        0:       act = m_flags;
                        1:       act = {3'b000, obs_br};
                        default: act = {3'b000, obs_rw};
                    endcase
                    n_chk++;
                    if (act !== pin_exp) begin
                        n_fail++;
                        $display("FAIL pin%0d actual=%b required=%b", pin_id, act, pin_exp);
                    end
                end
                obs_rw = 1'b0;
            end else if (cur_step >= 0 && RegWrite) begin
                obs_rw = 1'b1;
            end
            if (cur_step == S_BR) obs_br = PCWrite;
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        cur_step = -1;
        m_flags  = '0;
        m_cx     = 1'b1;
        exp_vec  = reset_out();
        chk_en   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] rd, input logic fix, input logic [3:0] af,
                             input int abort_at, input logic p_en, input int p_id,
                             input logic [3:0] p_exp);
        int seq[5];
        int len;
        seq[0] = S_F; seq[1] = S_D; len = 2;
        case (o)
            2'b01: begin seq[2] = S_MA; if (f[0]) begin seq[3] = S_MR; seq[4] = S_MWB; len = 5; end
                                        else begin seq[3] = S_MWR; len = 4; end end
            2'b00: begin seq[2] = f[5] ? S_EI : S_ER; seq[3] = S_AW; len = 4; end
            2'b10: begin seq[2] = S_BR; len = 3; end
            default: len = 2;
        endcase
        Cond = c; Op = o; Funct = f; Rd = rd;
        pin_en = p_en; pin_id = p_id; pin_exp = p_exp;
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
            ALUFlags = fix ? af : 4'($urandom);
            cur_step = seq[k];
            exp_vec  = model_out(seq[k]);
            @(posedge clk);
            if (seq[k] == S_D) m_cx = condex(Cond, m_flags);
            if ((seq[k] == S_ER || seq[k] == S_EI) && Funct[0] && m_cx) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (alu_sel(Funct[4:1]) <= 2'b01) m_flags[1:0] = ALUFlags[1:0];
            end
            #1;
            pin_en = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0;
        m_flags = '0; m_cx = 1'b1; exp_vec = '0;
        #1;
        do_reset();
        run_instr(4'he, 2'b00, 6'b001000, 4'd3, 1, 4'b0000, -1, 0, 0, 4'h0);   // ADD R3
        run_instr(4'he, 2'b00, 6'b010101, 4'd0, 1, 4'b0100, -1, 1, 2, 4'h1);   // CMP, Z set
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 1, 4'b0000, -1, 1, 0, 4'b0100); // BEQ taken
        run_instr(4'he, 2'b00, 6'b010101, 4'd0, 1, 4'b0000, -1, 1, 1, 4'h1);   // CMP, Z clear
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 1, 4'b0000, -1, 1, 0, 4'b0000); // BEQ not taken
        run_instr(4'he, 2'b00, 6'b010001, 4'd0, 1, 4'b1010, -1, 1, 1, 4'h0);   // TST S
        run_instr(4'he, 2'b01, 6'b011001, 4'd2, 1, 4'b0000, -1, 1, 0, 4'b1000); // LDR
        run_instr(4'he, 2'b00, 6'b010101, 4'd0, 1, 4'b0100, -1, 1, 2, 4'h1);   // CMP, Z set
        run_instr(4'h1, 2'b01, 6'b011000, 4'd4, 1, 4'b0000, -1, 1, 0, 4'b0100); // STRNE, skipped
        run_instr(4'he, 2'b00, 6'b001001, 4'd5, 1, 4'b1111, 2, 1, 2, 4'h0);    // ADDS aborted in EXECR
        run_instr(4'he, 2'b11, 6'b000000, 4'd0, 1, 4'b0000, -1, 1, 0, 4'b0000); // Op=11 after abort
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rc, cmd;
            logic [1:0] ro;
            logic [5:0] rf;
            int ab;
            logic [3:0] pool[8];
            pool = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1011, 4'b1000, 4'b0110};
            rc  = ($urandom_range(0, 3) == 0) ? 4'he : 4'($urandom);
            ro  = 2'($urandom);
            cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pool[$urandom_range(0, 7)];
            rf  = (ro == 2'b00) ? {1'($urandom), cmd, 1'($urandom)} : 6'($urandom);
            ab  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_instr(rc, ro, rf, ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom),
                      0, 4'h0, ab, 0, 0, 4'h0);
        end
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
